// File: rtl/abft_pkg.sv
// Shared constants and FSM encoding for the ABFT row checksum checker.
package abft_pkg;
  localparam int DATA_W    = 32;
  localparam int N_COLS    = 32;
  localparam int ROW_W     = (N_COLS + 1) * DATA_W;
  localparam int ROW_IDX_W = 5;
  localparam int COL_W     = $clog2(N_COLS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUM  = 2'd1,
    CMP  = 2'd2,
    OUT  = 2'd3
  } state_t;
endpackage

// File: rtl/row_checksum_checker_if.sv
// Result handshake toward the result writer: checked row data, error flag and syndrome.
interface row_checksum_checker_if;
  import abft_pkg::*;

  logic                       out_valid;
  logic                       out_ready;
  logic [N_COLS*DATA_W-1:0]   row_data_out;
  logic                       row_err;
  logic [DATA_W-1:0]          syndrome;

  modport master (
    output out_valid,
    output row_data_out,
    output row_err,
    output syndrome,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  row_data_out,
    input  row_err,
    input  syndrome,
    output out_ready
  );
endinterface

// File: rtl/rise_detect.sv
// Registered rising-edge detector for level strobes.
// Latency: rise is combinational from sig against last cycle's registered value.
// Backpressure: none.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise
);
  logic last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b0;
    end else begin
      last_q <= sig;
    end
  end

  assign rise = sig & ~last_q;
endmodule

// File: rtl/row_checksum_checker.sv
// ABFT row check: captures 32 data words + checksum, sums serially, flags mismatch; ABFT_ERR_INJECT_EN adds capture-time fault injection.
// Latency: out_valid rises 33 cycles after the capture edge (32 SUM cycles + 1 CMP).
// Backpressure: result held stable in OUT until out_ready; rows arriving while busy are dropped and flagged as overrun.
module row_checksum_checker
  import abft_pkg::*;
#(
  parameter int ERR_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  chk_enable,
  input  logic                  macs_ready,
  input  logic [ROW_W-1:0]      dataC_in,
`ifdef ABFT_ERR_INJECT_EN
  input  logic                  inj_arm,
  input  logic [5:0]            inj_col,
  input  logic [DATA_W-1:0]     inj_mask,
`endif
  row_checksum_checker_if.master res,
  output logic [ROW_IDX_W-1:0]  row_idx,
  output logic                  matrix_done,
  output logic [ERR_CNT_W-1:0]  err_count,
  output logic                  overrun,
  output logic                  busy
);

  state_t                          state;
  logic [N_COLS:0][DATA_W-1:0]     buf_q;
  logic [N_COLS:0][DATA_W-1:0]     cap_row;
  logic [DATA_W-1:0]               acc;
  logic [COL_W-1:0]                col;
  logic [DATA_W-1:0]               diff;
  logic                            rise;

  rise_detect u_rise (
    .clk   (clk),
    .rst_n (rst_n),
    .sig   (macs_ready),
    .rise  (rise)
  );

  always_comb begin
    cap_row = dataC_in;
`ifdef ABFT_ERR_INJECT_EN
    // Out-of-range columns (> N_COLS) disable injection; the checksum word may be hit.
    if (inj_arm && (inj_col <= 6'(N_COLS))) begin
      cap_row[inj_col] = cap_row[inj_col] ^ inj_mask;
    end
`endif
  end

  assign diff             = acc - buf_q[N_COLS];
  assign res.row_data_out = buf_q[N_COLS-1:0];
  assign busy             = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      buf_q         <= '0;
      acc           <= '0;
      col           <= '0;
      res.out_valid <= 1'b0;
      res.row_err   <= 1'b0;
      res.syndrome  <= '0;
      row_idx       <= '0;
      matrix_done   <= 1'b0;
      err_count     <= '0;
      overrun       <= 1'b0;
    end else begin
      matrix_done <= 1'b0;
      // Includes the handshake cycle in OUT: the state has not yet returned to IDLE.
      if (rise && (state != IDLE)) begin
        overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (rise && chk_enable) begin
            buf_q <= cap_row;
            acc   <= '0;
            col   <= '0;
            state <= SUM;
          end
        end

        SUM: begin
          acc <= acc + buf_q[{1'b0, col}];
          col <= col + 1'b1;
          if (col == COL_W'(N_COLS - 1)) begin
            state <= CMP;
          end
        end

        CMP: begin
          res.syndrome  <= diff;
          res.row_err   <= (diff != '0);
          if ((diff != '0) && !(&err_count)) begin
            err_count <= err_count + ERR_CNT_W'(1);
          end
          res.out_valid <= 1'b1;
          state         <= OUT;
        end

        OUT: begin
          if (res.out_valid && res.out_ready) begin
            res.out_valid <= 1'b0;
            state         <= IDLE;
            row_idx       <= row_idx + ROW_IDX_W'(1);
            if (row_idx == '1) begin
              matrix_done <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_row_checksum_checker.sv
// Directed-vector bench with a scoreboard queue and a decoupled output monitor.
module tb_row_checksum_checker;
  import abft_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 chk_enable;
  logic                 macs_ready;
  logic [ROW_W-1:0]     dataC_in;
  logic [ROW_IDX_W-1:0] row_idx;
  logic                 matrix_done;
  logic [15:0]          err_count;
  logic                 overrun;
  logic                 busy;
`ifdef ABFT_ERR_INJECT_EN
  logic                 inj_arm;
  logic [5:0]           inj_col;
  logic [DATA_W-1:0]    inj_mask;
`endif

  row_checksum_checker_if rif ();

  row_checksum_checker dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .chk_enable  (chk_enable),
    .macs_ready  (macs_ready),
    .dataC_in    (dataC_in),
`ifdef ABFT_ERR_INJECT_EN
    .inj_arm     (inj_arm),
    .inj_col     (inj_col),
    .inj_mask    (inj_mask),
`endif
    .res         (rif),
    .row_idx     (row_idx),
    .matrix_done (matrix_done),
    .err_count   (err_count),
    .overrun     (overrun),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N_COLS*DATA_W-1:0] data;
    logic [DATA_W-1:0]        syn;
    logic                     err;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [ROW_W-1:0] make_row(input logic [DATA_W-1:0] base,
                                                input logic [DATA_W-1:0] step,
                                                input logic [DATA_W-1:0] chk);
    logic [ROW_W-1:0] r;
    r = '0;
    for (int j = 0; j < N_COLS; j++) r[j*DATA_W +: DATA_W] = base + DATA_W'(j) * step;
    r[N_COLS*DATA_W +: DATA_W] = chk;
    return r;
  endfunction

  // Monitor: every accepted output must match the head of the scoreboard.
  initial begin
    exp_t e;
    int   bad;
    forever begin
      @(negedge clk);
      if (rst_n && rif.out_valid && rif.out_ready) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_output: got row with syndrome 0x%0h, expected no output", rif.syndrome);
        end else begin
          e = sb_q.pop_front();
          check("syndrome", 64'(rif.syndrome), 64'(e.syn));
          check("row_err", 64'(rif.row_err), 64'(e.err));
          bad = -1;
          for (int w = 0; w < N_COLS; w++)
            if (bad < 0 && rif.row_data_out[w*DATA_W +: DATA_W] !== e.data[w*DATA_W +: DATA_W]) bad = w;
          n_vec++;
          if (bad >= 0) begin
            n_err++;
            $display("FAIL row_data word %0d: got 0x%0h, expected 0x%0h", bad,
                     rif.row_data_out[bad*DATA_W +: DATA_W], e.data[bad*DATA_W +: DATA_W]);
          end
        end
      end
    end
  end

  // Issues one row; returns with out_valid high (ready=0) or just after the handshake edge (ready=1).
  task automatic send_row(input logic [ROW_W-1:0] row, input logic [N_COLS*DATA_W-1:0] exp_data,
                          input logic [DATA_W-1:0] exp_syn, input logic exp_err,
                          input logic ready, output int lat);
    exp_t e;
    int   k;
    k = 0;
    while (busy && k < 200) begin
      @(posedge clk); #1; k++;
    end
    if (busy) check("idle_timeout", 64'(busy), 64'(0));
    e.data = exp_data; e.syn = exp_syn; e.err = exp_err;
    sb_q.push_back(e);
    dataC_in      = row;
    macs_ready    = 1'b1;
    rif.out_ready = ready;
    @(posedge clk); #1;
    lat = 0;
    while (!rif.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 3) macs_ready = 1'b0;
    end
    macs_ready = 1'b0;
    if (!rif.out_valid) check("out_valid_timeout", 64'(rif.out_valid), 64'(1));
    if (ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    macs_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    logic [ROW_W-1:0] r;
    logic stable;
    #200000;
    $display("FAIL watchdog: got no completion, expected finish within 200us");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    logic [ROW_W-1:0] r;
    logic [ROW_W-1:0] r2;
    logic stable;
    logic [N_COLS*DATA_W-1:0] d;

    rst_n         = 1'b0;
    chk_enable    = 1'b1;
    macs_ready    = 1'b0;
    dataC_in      = '0;
    rif.out_ready = 1'b1;
`ifdef ABFT_ERR_INJECT_EN
    inj_arm  = 1'b0;
    inj_col  = 6'd0;
    inj_mask = '0;
`endif
    #12;
    check("rst_out_valid", 64'(rif.out_valid), 64'(0));
    check("rst_row_err", 64'(rif.row_err), 64'(0));
    check("rst_syndrome", 64'(rif.syndrome), 64'(0));
    check("rst_row_idx", 64'(row_idx), 64'(0));
    check("rst_err_count", 64'(err_count), 64'(0));
    check("rst_overrun_busy_mdone", {61'd0, overrun, busy, matrix_done}, 64'(0));
    check("rst_row_data_zero", 64'(rif.row_data_out != '0), 64'(0));
    do_reset();

    // Clean row: words 1..32, checksum 528.
    r = make_row(32'd1, 32'd1, 32'd528);
    send_row(r, r[N_COLS*DATA_W-1:0], 32'h0, 1'b0, 1'b1, lat);
    check("clean_latency", 64'(lat), 64'(33));
    check("clean_word5", 64'(rif.row_data_out[5*DATA_W +: DATA_W]), 64'(6));

    // Corrupt checksum 529.
    r = make_row(32'd1, 32'd1, 32'd529);
    send_row(r, r[N_COLS*DATA_W-1:0], 32'hFFFF_FFFF, 1'b1, 1'b1, lat);
    check("corrupt_err_count", 64'(err_count), 64'(1));

    // Wrap-around: 32 x 0xFFFFFFFF sums to 0xFFFFFFE0.
    r = make_row(32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFE0);
    send_row(r, r[N_COLS*DATA_W-1:0], 32'h0, 1'b0, 1'b1, lat);
    r = make_row(32'hFFFF_FFFF, 32'd0, 32'h0);
    send_row(r, r[N_COLS*DATA_W-1:0], 32'hFFFF_FFE0, 1'b1, 1'b1, lat);
    check("wrap_err_count", 64'(err_count), 64'(2));
    check("wrap_row_idx", 64'(row_idx), 64'(4));

    // Reset mid-SUM abandons the row.
    r = make_row(32'd10, 32'd2, 32'd0);
    dataC_in   = r;
    macs_ready = 1'b1;
    @(posedge clk); #1;
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_out_valid", 64'(rif.out_valid), 64'(0));
    check("midrst_err_count", 64'(err_count), 64'(0));
    check("midrst_row_idx", 64'(row_idx), 64'(0));
    check("midrst_row_data_zero", 64'(rif.row_data_out != '0), 64'(0));
    macs_ready = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    r = make_row(32'd1, 32'd1, 32'd528);
    send_row(r, r[N_COLS*DATA_W-1:0], 32'h0, 1'b0, 1'b1, lat);
    check("postrst_latency", 64'(lat), 64'(33));
    check("postrst_row_idx", 64'(row_idx), 64'(1));

    // Backpressure with a second row arriving during OUT.
    r  = make_row(32'd7, 32'd3, 32'd1712);
    r2 = make_row(32'hDEAD_0000, 32'd1, 32'd5);
    send_row(r, r[N_COLS*DATA_W-1:0], 32'h0, 1'b0, 1'b0, lat);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin dataC_in = r2; macs_ready = 1'b1; end
      if (i == 6) macs_ready = 1'b0;
      @(posedge clk); #1;
      if (!rif.out_valid || rif.syndrome !== 32'h0 || rif.row_err !== 1'b0 ||
          rif.row_data_out !== r[N_COLS*DATA_W-1:0]) stable = 1'b0;
    end
    check("bp_stable", 64'(stable), 64'(1));
    check("bp_overrun", 64'(overrun), 64'(1));
    rif.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_out_valid_drop", 64'(rif.out_valid), 64'(0));
    check("bp_row_idx", 64'(row_idx), 64'(2));
    repeat (40) @(posedge clk);
    #1;
    check("bp_no_dropped_row", 64'(busy | rif.out_valid), 64'(0));

    // Matrix completion over 32 clean rows.
    do_reset();
    check("mx_overrun_cleared", 64'(overrun), 64'(0));
    for (int k = 0; k < 32; k++) begin
      r = make_row(32'(k * 100), 32'd1, 32'(k * 3200 + 496));
      send_row(r, r[N_COLS*DATA_W-1:0], 32'h0, 1'b0, 1'b1, lat);
      check("mx_matrix_done", 64'(matrix_done), 64'(k == 31));
    end
    @(posedge clk); #1;
    check("mx_done_pulse_end", 64'(matrix_done), 64'(0));
    check("mx_row_idx", 64'(row_idx), 64'(0));
    check("mx_err_count", 64'(err_count), 64'(0));

`ifdef ABFT_ERR_INJECT_EN
    // Word 3 = 4 becomes 5, sum 529 against checksum 528.
    do_reset();
    inj_arm  = 1'b1;
    inj_col  = 6'd3;
    inj_mask = 32'h1;
    r = make_row(32'd1, 32'd1, 32'd528);
    d = r[N_COLS*DATA_W-1:0];
    d[3*DATA_W +: DATA_W] = 32'd5;
    send_row(r, d, 32'h1, 1'b1, 1'b1, lat);
    inj_arm = 1'b0;
    check("inj_err_count", 64'(err_count), 64'(1));
`else
    d = '0;
`endif

    repeat (3) @(posedge clk);
    check("sb_drained", 64'(sb_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
